// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - round/lives sequencer driving play enable, round reset and screen override
module game_flow_ctrl #(
    parameter int LIVES         = 3,
    parameter int LIVES_W       = 2,
    parameter int INVULN_FRAMES = 120,
    parameter int DYING_FRAMES  = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_pulse,
    input  logic               frame_tick,
    input  logic               death_in,
    input  logic               all_killed,
    output logic [2:0]         state,
    output logic [LIVES_W-1:0] lives,
    output logic               round_reset,
    output logic               play_en,
    output logic               invuln,
    output logic               screen_override,
    output logic [11:0]        screen_rgb
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_RESPAWN   = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } game_state_t;

    localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(LIVES);
    localparam logic [7:0]         INVULN_INIT = 8'(INVULN_FRAMES);
    localparam logic [7:0]         DYING_INIT  = 8'(DYING_FRAMES);
    localparam logic [11:0]        RGB_RED     = 12'hF00;
    localparam logic [11:0]        RGB_GREEN   = 12'h0F0;

    game_state_t        state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [7:0]         invuln_cnt_q, invuln_cnt_d;
    logic [7:0]         dying_cnt_q, dying_cnt_d;
    logic               round_reset_d;
    logic               play_en_d;
    logic               invuln_d;
    logic               override_d;
    logic [11:0]        rgb_d;

    // Next-state, counter and output decode; outputs follow the next state so they are registered with it
    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        invuln_cnt_d  = invuln_cnt_q;
        dying_cnt_d   = dying_cnt_q;
        round_reset_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_d       = ST_PLAY;
                    round_reset_d = 1'b1;
                    invuln_cnt_d  = INVULN_INIT;
                end
            end
            ST_PLAY: begin
                if (frame_tick && invuln_cnt_q != 8'd0) begin
                    invuln_cnt_d = invuln_cnt_q - 8'd1;
                end
                // Death outranks a simultaneous win; immunity only gates death
                if (death_in && invuln_cnt_q == 8'd0) begin
                    state_d     = ST_DYING;
                    lives_d     = lives_q - 1'b1;
                    dying_cnt_d = DYING_INIT;
                end else if (all_killed) begin
                    state_d = ST_WIN;
                end
            end
            ST_DYING: begin
                if (dying_cnt_q == 8'd0) begin
                    if (lives_q == '0) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d       = ST_RESPAWN;
                        round_reset_d = 1'b1;
                        invuln_cnt_d  = INVULN_INIT;
                    end
                end else if (frame_tick) begin
                    dying_cnt_d = dying_cnt_q - 8'd1;
                end
            end
            ST_RESPAWN: begin
                state_d = ST_PLAY;
            end
            ST_GAME_OVER, ST_WIN: begin
                if (start_pulse) begin
                    state_d = ST_IDLE;
                    lives_d = LIVES_INIT;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                lives_d      = LIVES_INIT;
                invuln_cnt_d = 8'd0;
                dying_cnt_d  = 8'd0;
            end
        endcase

        play_en_d  = (state_d == ST_PLAY);
        invuln_d   = (invuln_cnt_d != 8'd0);
        override_d = (state_d == ST_DYING) || (state_d == ST_GAME_OVER) || (state_d == ST_WIN);
        if (state_d == ST_WIN) begin
            rgb_d = RGB_GREEN;
        end else if (override_d) begin
            rgb_d = RGB_RED;
        end else begin
            rgb_d = 12'h000;
        end
    end

    // State, counters and registered outputs; reset overrides any count in progress
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            lives_q         <= LIVES_INIT;
            invuln_cnt_q    <= 8'd0;
            dying_cnt_q     <= 8'd0;
            round_reset     <= 1'b0;
            play_en         <= 1'b0;
            invuln          <= 1'b0;
            screen_override <= 1'b0;
            screen_rgb      <= 12'h000;
        end else begin
            state_q         <= state_d;
            lives_q         <= lives_d;
            invuln_cnt_q    <= invuln_cnt_d;
            dying_cnt_q     <= dying_cnt_d;
            round_reset     <= round_reset_d;
            play_en         <= play_en_d;
            invuln          <= invuln_d;
            screen_override <= override_d;
            screen_rgb      <= rgb_d;
        end
    end

    assign state = state_q;
    assign lives = lives_q;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Round/lives sequencer that sits directly upstream of the top-level pixel mux.
- Consumes the aggregated death indication, the all-enemies-killed indication and the centre-button single-clock pulse.
- Produces:
  - the game state;
  - a one-cycle round_reset that re-seeds the bomberman and enemy positions;
  - a play enable and an invulnerability flag;
  - a full-screen colour override (red for lose, green for win) that the pixel mux applies ahead of the sprite layers.

Parameters:
- LIVES, 3, lives loaded at reset and on restart (1..2^LIVES_W-1).
- LIVES_W, 2, width of the lives counter.
- INVULN_FRAMES, 120, frames of death immunity after a round (re)start (0..255).
- DYING_FRAMES, 60, frames the red death screen is held before respawn or game over (1..255).

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-low reset.
- start_pulse  in  1  one-clock pulse (debounced centre button SCEN).
- frame_tick  in  1  one-clock pulse once per video frame.
- death_in  in  1  level; OR of all enemy death signals and game_over.
- all_killed  in  1  level; AND of all enemy_killed flags.
- state  out  3  IDLE=0, PLAY=1, DYING=2, RESPAWN=3, GAME_OVER=4, WIN=5.
- lives  out  LIVES_W  remaining lives.
- round_reset  out  1  one-clock pulse; re-seeds player and enemies.
- play_en  out  1  high only in PLAY; gates movement and bomb placement.
- invuln  out  1  high while the invulnerability counter is non-zero.
- screen_override  out  1  when high, the pixel mux outputs screen_rgb for every bright pixel.
- screen_rgb  out  12  override colour {R,G,B}.

Behaviour:
- **Timing.** All outputs are registered and update on the clk edge after the causing input. Inputs are sampled only on rising clk.
- **Reset** (reset==0 at a clk edge, takes effect that edge, overrides everything including mid-count):
  - state=IDLE, lives=LIVES;
  - invuln counter=0, dying counter=0;
  - round_reset=0, play_en=0, invuln=0;
  - screen_override=0, screen_rgb=12'h000.
- **IDLE:**
  - start_pulse -> PLAY; round_reset=1 for exactly one cycle; invuln counter=INVULN_FRAMES.
  - Otherwise stay.
  - death_in and all_killed are ignored.
- **PLAY** (play_en=1). Evaluated in priority order:
  1. death_in && invuln counter==0 -> DYING; lives decrements by 1; dying counter=DYING_FRAMES.
  2. Else all_killed -> WIN.
  3. Death wins over a simultaneous all_killed.
  - death_in while invuln is high is ignored.
  - frame_tick decrements the invuln counter, saturating at 0.
  - start_pulse is ignored.
- **DYING:**
  - screen_override=1, screen_rgb=12'hF00.
  - frame_tick decrements the dying counter.
  - When the counter is 0, on the next clock: lives==0 -> GAME_OVER, else -> RESPAWN.
  - A frame_tick on the cycle the counter is already 0 has no effect (no underflow).
- **RESPAWN:**
  - Lasts exactly one cycle; round_reset=1; invuln counter=INVULN_FRAMES; then -> PLAY.
  - screen_override drops to 0 on entry.
- **GAME_OVER:**
  - screen_override=1, screen_rgb=12'hF00.
  - start_pulse -> IDLE; lives=LIVES; override cleared.
- **WIN:**
  - screen_override=1, screen_rgb=12'h0F0.
  - start_pulse -> IDLE; lives=LIVES.
- **Outputs and encoding:**
  - invuln = (invuln counter != 0), registered.
  - In IDLE, PLAY and RESPAWN, screen_override=0 and screen_rgb=12'h000.
  - Lives arithmetic is unsigned and never wraps: a decrement is only possible from lives>=1, because reaching 0 forces GAME_OVER.
  - Unused state encodings 6 and 7 recover to IDLE on the next clock with all outputs at their reset values.

Test Plan:
- **Reset and start.** Hold reset=0 for 2 clk, release, pulse start_pulse -> next cycle state=1, play_en=1, round_reset=1 for exactly 1 cycle, lives=3, invuln=1.
- **Invulnerability window.** With INVULN_FRAMES=4, assert death_in during frames 1-3 -> state stays 1. After the 4th frame_tick, invuln=0 and death_in -> state=2, lives=2, screen_rgb=F00.
- **Death and respawn.** With DYING_FRAMES=3, deliver 3 frame_ticks in DYING -> state=3 for one cycle with round_reset=1, then state=1 with invuln=1 and screen_override=0.
- **Game over after three deaths.** Three deaths -> lives=0 -> after the dying hold, state=4 with screen_rgb=F00. start_pulse -> state=0, lives=3.
- **Simultaneous death and win.** death_in=1 and all_killed=1 on the same cycle with invuln=0 -> state=2, not 5. Separately, all_killed alone -> state=5, screen_rgb=0F0, and start_pulse returns to IDLE.
- **Reset mid-operation.** reset=0 mid-DYING with the counter at 2 -> next edge state=0, screen_override=0, lives=3, and no stale round_reset after release.
